// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, one-hot status codes and sequencer states.
package y86_pkg;

  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  localparam logic [3:0] STAT_AOK = 4'b0001;
  localparam logic [3:0] STAT_HLT = 4'b0010;
  localparam logic [3:0] STAT_ADR = 4'b0100;
  localparam logic [3:0] STAT_INS = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2,
    ST_FAULT  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/pc_select.sv
// Combinational next-PC mux: call and taken jumps go to valC, ret to valM, all else valP.
module pc_select
  import y86_pkg::*;
(
  input  logic [3:0]  icode,
  input  logic        cnd,
  input  logic [63:0] valC,
  input  logic [63:0] valP,
  input  logic [63:0] valM,
  output logic [63:0] next_pc
);

  always_comb begin
    next_pc = valP;
    case (icode)
      I_CALL:  next_pc = valC;
      I_JXX:   next_pc = cnd ? valC : valP;
      I_RET:   next_pc = valM;
      default: next_pc = valP;
    endcase
  end

endmodule

// File: rtl/seq_pc_control.sv
// PC sequencer for the SEQ Y86-64 core: owns the PC, status, run/step FSM and
// retired-instruction / RUN-cycle counters.
//
// state  | meaning
// IDLE   | waiting for start after reset
// RUN    | executing, free-run or one instruction per step
// HALTED | halt retired-less stop; only reset leaves
// FAULT  | address or instruction fault; only reset leaves
module seq_pc_control
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  input  logic [3:0]       icode,
  input  logic             cnd,
  input  logic [63:0]      valC,
  input  logic [63:0]      valP,
  input  logic [63:0]      valM,
  input  logic [3:0]       stat_f,
  input  logic             dmem_err,
  output logic [63:0]      pc,
  output logic             commit,
  output logic [3:0]       stat,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  seq_state_e       state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic [3:0]       stat_q, stat_d;
  logic [CNT_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [63:0]      next_pc;
  logic             go;

  pc_select u_pc_select (
    .icode   (icode),
    .cnd     (cnd),
    .valC    (valC),
    .valP    (valP),
    .valM    (valM),
    .next_pc (next_pc)
  );

  assign go = (state_q == ST_RUN) && (!step_mode || step);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stat_d  = stat_q;
    instr_d = instr_q;
    cycle_d = cycle_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        cycle_d = cycle_q + CNT_W'(1);
        if (go) begin
          // Fault checks outrank halt; pc holds on the offending instruction.
          if (stat_f[3] || stat_f[2]) begin
            state_d = ST_FAULT;
            stat_d  = stat_f;
          end else if (dmem_err) begin
            state_d = ST_FAULT;
            stat_d  = STAT_ADR;
          end else if (icode == I_HALT || stat_f[1]) begin
            state_d = ST_HALTED;
            stat_d  = STAT_HLT;
          end else begin
            commit  = 1'b1;
            pc_d    = next_pc;
            instr_d = instr_q + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      stat_q  <= STAT_AOK;
      instr_q <= '0;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stat_q  <= stat_d;
      instr_q <= instr_d;
      cycle_q <= cycle_d;
    end
  end

  assign pc        = pc_q;
  assign stat      = stat_q;
  assign state     = state_q;
  assign instr_cnt = instr_q;
  assign cycle_cnt = cycle_q;

endmodule

// File: tb/tb_seq_pc_control.sv
// Directed bench for seq_pc_control: a behavioural reference checked every
// cycle, plus literal expectations from the scenario walk-throughs.
module tb_seq_pc_control;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, step_mode, step, cnd, dmem_err;
  logic [3:0]  icode, stat_f;
  logic [63:0] valC, valP, valM;
  logic [63:0] pc;
  logic        commit;
  logic [3:0]  stat;
  logic [1:0]  state;
  logic [31:0] instr_cnt, cycle_cnt;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // reference model: 0 idle, 1 run, 2 halted, 3 fault
  logic [63:0] m_pc;
  int          m_state;
  logic [3:0]  m_stat;
  logic [31:0] m_icnt, m_ccnt;

  seq_pc_control #(.RESET_PC(64'h0), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .step_mode(step_mode), .step(step),
    .icode(icode), .cnd(cnd), .valC(valC), .valP(valP), .valM(valM),
    .stat_f(stat_f), .dmem_err(dmem_err), .pc(pc), .commit(commit),
    .stat(stat), .state(state), .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_next_pc();
    if (icode == 4'h8) return valC;
    if (icode == 4'h7 && cnd) return valC;
    if (icode == 4'h9) return valM;
    return valP;
  endfunction

  function automatic bit ref_advance();
    return (m_state == 1) && (!step_mode || step);
  endfunction

  function automatic bit ref_commit();
    return ref_advance() && stat_f == 4'b0001 && !dmem_err && icode != 4'h0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc = 64'h0; m_state = 0; m_stat = 4'b0001; m_icnt = 0; m_ccnt = 0;
    end else if (m_state == 0) begin
      if (start) m_state = 1;
    end else if (m_state == 1) begin
      m_ccnt = m_ccnt + 1;
      if (ref_advance()) begin
        if (stat_f[3] || stat_f[2]) begin m_state = 3; m_stat = stat_f; end
        else if (dmem_err) begin m_state = 3; m_stat = 4'b0100; end
        else if (icode == 4'h0 || stat_f[1]) begin m_state = 2; m_stat = 4'b0010; end
        else begin m_pc = ref_next_pc(); m_icnt = m_icnt + 1; end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", pc, m_pc);
      chk("state", 64'(state), 64'(m_state));
      chk("stat", 64'(stat), 64'(m_stat));
      chk("instr_cnt", 64'(instr_cnt), 64'(m_icnt));
      chk("cycle_cnt", 64'(cycle_cnt), 64'(m_ccnt));
      chk("commit", 64'(commit), 64'(ref_commit()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic defaults();
    start = 0; step_mode = 0; step = 0; icode = 4'h1; cnd = 0;
    valC = 0; valP = 0; valM = 0; stat_f = 4'b0001; dmem_err = 0;
  endtask

  task automatic do_reset();
    defaults();
    reset = 1;
    #1;
    chk("rst_pc", pc, 64'h0);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_cnt", 64'(instr_cnt) | 64'(cycle_cnt), 64'd0);
    tick();
    reset = 0;
  endtask

  task automatic go_run();
    start = 1; tick(); start = 0;
  endtask

  task automatic instr(input logic [3:0] ic, input logic [63:0] p);
    icode = ic; valP = p; tick();
  endtask

  initial begin
    defaults();
    reset = 1;
    tick(); tick();
    reset = 0;
    chk("init_stat", 64'(stat), 64'b0001);
    chk_en = 1;

    // free-run nop, irmovq, halt
    go_run();
    chk("s1_pc0", pc, 64'h0);
    instr(4'h1, 64'd1);  chk("s1_pc1", pc, 64'd1);
    instr(4'h3, 64'd11); chk("s1_pc2", pc, 64'd11);
    icode = 4'h0; valP = 64'd12; #1;
    chk("s1_halt_commit", 64'(commit), 64'd0);
    tick(); tick(); tick();
    chk("s1_pc_hold", pc, 64'd11);
    chk("s1_state", 64'(state), 64'd2);
    chk("s1_stat", 64'(stat), 64'b0010);
    chk("s1_icnt", 64'(instr_cnt), 64'd2);
    chk("s1_ccnt", 64'(cycle_cnt), 64'd3);

    // jXX taken / not taken at 0x20
    do_reset(); go_run();
    instr(4'h1, 64'h20);
    icode = 4'h7; cnd = 1; valC = 64'h100; valP = 64'h29; tick();
    chk("jxx_taken", pc, 64'h100);
    do_reset(); go_run();
    instr(4'h1, 64'h20);
    icode = 4'h7; cnd = 0; valC = 64'h100; valP = 64'h29; tick();
    chk("jxx_not_taken", pc, 64'h29);

    // call then ret
    do_reset(); go_run();
    icode = 4'h8; valC = 64'h80; valP = 64'h9; tick();
    chk("call_pc", pc, 64'h80);
    chk("call_icnt", 64'(instr_cnt), 64'd1);
    icode = 4'h9; valM = 64'h0A; valP = 64'h81; tick();
    chk("ret_pc", pc, 64'h0A);
    chk("ret_icnt", 64'(instr_cnt), 64'd2);

    // single-step: pulses in RUN cycles 3 and 7
    do_reset(); step_mode = 1; go_run();
    for (int c = 1; c <= 9; c++) begin
      step = (c == 3 || c == 7);
      icode = 4'h1; valP = 64'(c) * 64'h100;
      #1;
      chk("step_commit", 64'(commit), 64'(c == 3 || c == 7));
      tick();
    end
    step = 0;
    chk("step_pc", pc, 64'h700);
    chk("step_icnt", 64'(instr_cnt), 64'd2);
    chk("step_ccnt", 64'(cycle_cnt), 64'd9);

    // INS fault at 0x40, later start ignored
    do_reset(); go_run();
    instr(4'h1, 64'h40);
    icode = 4'h6; valP = 64'h42; stat_f = 4'b1000; #1;
    chk("ins_commit", 64'(commit), 64'd0);
    tick();
    stat_f = 4'b0001; start = 1; tick(); start = 0; tick();
    chk("ins_state", 64'(state), 64'd3);
    chk("ins_stat", 64'(stat), 64'b1000);
    chk("ins_pc", pc, 64'h40);

    // data-memory error
    do_reset(); go_run();
    icode = 4'h5; valP = 64'hA; dmem_err = 1; tick(); dmem_err = 0; tick();
    chk("adr_stat", 64'(stat), 64'b0100);
    chk("adr_state", 64'(state), 64'd3);
    chk("adr_pc", pc, 64'h0);

    // async reset mid-run at 0x55, then wrap from all-ones
    do_reset(); go_run();
    instr(4'h1, 64'h55);
    chk("pre_rst_pc", pc, 64'h55);
    do_reset(); go_run();
    instr(4'h1, 64'hFFFF_FFFF_FFFF_FFFF);
    instr(4'h1, 64'h9);
    chk("wrap_pc", pc, 64'h9);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
